// File: rtl/pio_data_sequencer.sv
// rtl/pio_data_sequencer.sv - FIFO-buffered word presenter with req/ack toggle handshake to an HPS PIO
// Optional feature: define PIO_DATA_SEQ_ACK_SYNC_EN to pass hps_ack through a 2-flop synchronizer.
module pio_data_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        hps_ack,
    input  logic        hps_clear,
    output logic [31:0] data_out,
    output logic [7:0]  status_out
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count;
    logic          req;
    logic          ack_s;
    logic          push, pop;

`ifdef PIO_DATA_SEQ_ACK_SYNC_EN
    logic ack_meta, ack_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= hps_ack;
            ack_sync <= ack_meta;
        end
    end

    assign ack_s = ack_sync;
`else
    assign ack_s = hps_ack;
`endif

    // Acceptance depends only on the registered count, so a full FIFO refuses even while popping.
    assign in_ready = (count < DEPTH_C);
    assign push     = in_valid && in_ready && !hps_clear;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ack_s == req && count != 4'd0) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ack_s == req) begin
                    if (count != 4'd0) pop = 1'b1;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (hps_clear) begin
            pop     = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 4'd0;
            data_out <= 32'd0;
            req      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hps_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= 4'd0;
                data_out <= 32'd0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) begin
                    rd_ptr   <= rd_ptr + AW'(1);
                    data_out <= mem[rd_ptr];
                    req      <= ~req;
                end
                case ({push, pop})
                    2'b10:   count <= count + 4'd1;
                    2'b01:   count <= count - 4'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    assign status_out = {count, (count == 4'd0), (count == DEPTH_C), (state_q == WAIT), req};

endmodule
